// File: rtl/multu_hilo.sv
// multu_hilo -- sequential unsigned shift-add multiplier with HI/LO result
// registers. It takes its function code and operand-load pulse from the ALU
// control stage. It runs MULTU over WIDTH clock iterations and holds the
// 2*WIDTH-bit product until the HI/LO-write code commits it. It also serves
// MFHI/MFLO reads to the result mux.
//
// Handshake: a load is the function code MULTU together with mulreset=1.
// busy is high for exactly the WIDTH iteration edges that follow the last
// load edge. done is high from then until a HILO_WR edge commits the
// product. HILO_WR has no effect unless done is high.
//
// Ports:
//   clk       system clock, rising edge
//   reset     asynchronous, active-low; clears all state
//   Signal    6-bit function code from ALU control
//   mulreset  operand-load request (active-high)
//   dataA     multiplicand
//   dataB     multiplier
//   dataOut   HI (MFHI) / LO (MFLO) read data, 0 for any other code
//   busy      iteration sequence in progress
//   done      finished product waiting for HILO_WR
//   dbg_state current FSM state (0 IDLE, 1 RUN, 2 DONE)
module multu_hilo #(
  parameter int          WIDTH   = 32,
  parameter logic [5:0]  MULTU   = 6'b011001,
  parameter logic [5:0]  MFHI    = 6'b010000,
  parameter logic [5:0]  MFLO    = 6'b010010,
  parameter logic [5:0]  HILO_WR = 6'b111111
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       Signal,
  input  logic             mulreset,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  output logic [WIDTH-1:0] dataOut,
  output logic             busy,
  output logic             done,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [2*WIDTH-1:0] p;
  logic [WIDTH-1:0]   m;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   hi, lo;

  logic               load, iter, last_iter, commit;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] p_shift;

  // A load wins over everything, including an iteration in progress.
  assign load      = (Signal == MULTU) && mulreset;
  assign iter      = (state == S_RUN) && !mulreset;
  assign last_iter = iter && (cnt == CW'(WIDTH - 1));
  assign commit    = (state == S_DONE) && (Signal == HILO_WR) && !load;

  // Add the multiplicand into the upper half when the current multiplier bit
  // is set. The sum is kept at WIDTH+1 bits so that its carry shifts into
  // the top of P and is not lost.
  always_comb begin
    sum     = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, m} : '0);
    p_shift = {sum, p[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (load) begin
      state_nxt = S_RUN;
    end else begin
      case (state)
        S_RUN:   if (last_iter) state_nxt = S_DONE;
        S_DONE:  if (Signal == HILO_WR) state_nxt = S_IDLE;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p   <= '0;
      m   <= '0;
      cnt <= '0;
      hi  <= '0;
      lo  <= '0;
    end else begin
      if (load) begin
        p   <= {{WIDTH{1'b0}}, dataB};
        m   <= dataA;
        cnt <= '0;
      end else if (iter) begin
        p   <= p_shift;
        cnt <= cnt + CW'(1);
      end
      if (commit) begin
        hi <= p[2*WIDTH-1:WIDTH];
        lo <= p[WIDTH-1:0];
      end
    end
  end

  assign busy      = (state == S_RUN);
  assign done      = (state == S_DONE);
  assign dbg_state = state;

  always_comb begin
    dataOut = '0;
    if (Signal == MFHI)      dataOut = hi;
    else if (Signal == MFLO) dataOut = lo;
  end

endmodule

// File: tb/tb_multu_hilo.sv
module tb_multu_hilo;

  localparam int         WIDTH   = 32;
  localparam logic [5:0] MULTU   = 6'b011001;
  localparam logic [5:0] MFHI    = 6'b010000;
  localparam logic [5:0] MFLO    = 6'b010010;
  localparam logic [5:0] HILO_WR = 6'b111111;
  localparam logic [5:0] NOP     = 6'b000000;

  logic             clk = 1'b0;
  logic             reset;
  logic [5:0]       sig;
  logic             mulreset;
  logic [WIDTH-1:0] dataA, dataB;
  logic [WIDTH-1:0] dataOut;
  logic             busy, done;
  logic [1:0]       dbg_state;

  multu_hilo dut (
    .clk       (clk),
    .reset     (reset),
    .Signal    (sig),
    .mulreset  (mulreset),
    .dataA     (dataA),
    .dataB     (dataB),
    .dataOut   (dataOut),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;

  logic [WIDTH-1:0] exp_q[$];

  // Reference model: what HI/LO hold, and the product a load has started.
  logic [WIDTH-1:0]   model_hi = '0;
  logic [WIDTH-1:0]   model_lo = '0;
  logic [2*WIDTH-1:0] pending_prod = '0;
  bit                 pending = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input int ncyc);
    dataA    = a;
    dataB    = b;
    sig      = MULTU;
    mulreset = 1'b1;
    repeat (ncyc) step();
    check("busy_after_load", busy, 1);
    mulreset     = 1'b0;
    sig          = NOP;
    pending_prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    pending      = 1'b1;
  endtask

  // done must rise on exactly the WIDTH-th edge after mulreset falls.
  task automatic run_to_done();
    repeat (WIDTH - 1) step();
    check("busy_before_last", busy, 1);
    check("done_before_last", done, 0);
    step();
    check("busy_at_done", busy, 0);
    check("done_at_done", done, 1);
  endtask

  task automatic commit_op();
    sig = HILO_WR;
    step();
    sig = NOP;
    if (pending) begin
      model_hi = pending_prod[2*WIDTH-1:WIDTH];
      model_lo = pending_prod[WIDTH-1:0];
      pending  = 1'b0;
    end
    check("done_after_commit", done, 0);
    check("busy_after_commit", busy, 0);
  endtask

  // Each read code is held across exactly one falling edge, where the
  // monitor consumes the matching expectation.
  task automatic read_both();
    sig = MFHI;
    exp_q.push_back(model_hi);
    step();
    sig = MFLO;
    exp_q.push_back(model_lo);
    step();
    sig = NOP;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (sig == MFHI || sig == MFLO) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL read_unexpected: got %0h expected no read at %0t", dataOut, $time);
      end else begin
        logic [WIDTH-1:0] e;
        e = exp_q.pop_front();
        check((sig == MFHI) ? "mfhi" : "mflo", dataOut, e);
      end
    end else if (sig == NOP) begin
      check("dataout_other_code", dataOut, 0);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [WIDTH-1:0] ra, rb;
    reset    = 1'b0;
    sig      = NOP;
    mulreset = 1'b0;
    dataA    = '0;
    dataB    = '0;

    // Reset then idle
    step();
    step();
    check("busy_in_reset", busy, 0);
    check("done_in_reset", done, 0);
    reset = 1'b1;
    step();
    check("busy_idle", busy, 0);
    check("done_idle", done, 0);
    read_both();

    // Basic 3 x 5 with a two-edge load
    load_op(32'd3, 32'd5, 2);
    run_to_done();
    commit_op();
    read_both();

    // Max operands: carry retention
    load_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    run_to_done();
    commit_op();
    read_both();

    // Upper carry, with an early HILO_WR at iteration 10 that must be ignored
    load_op(32'h8000_0000, 32'd2, 1);
    repeat (9) step();
    sig = HILO_WR;
    step();
    check("busy_after_early_wr", busy, 1);
    check("done_after_early_wr", done, 0);
    read_both();                 // iterations 11 and 12: HI/LO still old
    repeat (WIDTH - 13) step();
    check("busy_before_last_uc", busy, 1);
    step();
    check("done_uc", done, 1);
    commit_op();
    read_both();

    // Restart: 7 x 9 aborted at iteration 15, reloaded with 6 x 6
    load_op(32'd7, 32'd9, 1);
    repeat (15) step();
    check("busy_mid_restart", busy, 1);
    load_op(32'd6, 32'd6, 1);
    run_to_done();
    commit_op();
    read_both();

    // Random products, random hold in DONE, HILO_WR in IDLE ignored
    for (int i = 0; i < 10; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i == 0) ra = '0;
      if (i == 1) rb = 32'd1;
      load_op(ra, rb, $urandom_range(1, 3));
      run_to_done();
      repeat ($urandom_range(0, 3)) step();
      check("done_hold", done, 1);
      commit_op();
      read_both();
      sig = HILO_WR;
      step();
      sig = NOP;
      check("busy_idle_wr", busy, 0);
      read_both();
    end

    // Async reset between edges at iteration 20
    load_op(32'd11, 32'd13, 1);
    repeat (20) step();
    #2;
    reset = 1'b0;
    sig   = MFHI;
    model_hi = '0;
    model_lo = '0;
    pending  = 1'b0;
    exp_q.push_back(model_hi);
    #1;
    check("busy_async_reset", busy, 0);
    check("done_async_reset", done, 0);
    check("hi_async_reset", dataOut, 0);
    step();
    sig = MFLO;
    exp_q.push_back(model_lo);
    step();
    sig   = NOP;
    reset = 1'b1;
    step();
    load_op(32'd2, 32'd2, 1);
    run_to_done();
    commit_op();
    read_both();

    repeat (2) step();
    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multu_hilo.md
Name: multu_hilo

Overview:
Sequential 32-bit unsigned shift-add multiplier with HI/LO result registers. Sits directly downstream of the ALU control stage and consumes its 6-bit function code (SignaltoMUL) and its mulreset pulse. Computes MULTU over WIDTH clock iterations, commits the 64-bit product to HI/LO on the control stage's HI/LO-write code, and serves MFHI/MFLO reads to the result mux.

Parameters:
WIDTH, 32, operand width; product width is 2*WIDTH
MULTU, 6'b011001, function code: multiply unsigned
MFHI, 6'b010000, function code: read HI
MFLO, 6'b010010, function code: read LO
HILO_WR, 6'b111111, function code: commit product to HI/LO

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-low; clears all state immediately
Signal  input  6  function code from ALU control
mulreset  input  1  active-high operand-load request from ALU control
dataA  input  WIDTH  multiplicand
dataB  input  WIDTH  multiplier
dataOut  output  WIDTH  HI/LO read data
busy  output  1  high while an iteration sequence is in progress
done  output  1  high while a finished product waits for HILO_WR

Behaviour:
- Internal state: 2*WIDTH product register P, iteration counter cnt (log2(WIDTH)+1 bits), HI, LO (WIDTH each), FSM in {IDLE, RUN, DONE}.
- Reset (reset==0, asynchronous): P=0, cnt=0, HI=0, LO=0, FSM=IDLE, busy=0, done=0, dataOut=0.
- Load: on any edge where Signal==MULTU and mulreset==1, from any state: P={WIDTH'b0, dataB}, multiplicand register M=dataA, cnt=0, FSM=RUN. Repeated load cycles are idempotent and restart the operation; a load mid-RUN or in DONE aborts the previous product.
- RUN iteration: on each edge in RUN with mulreset==0, regardless of Signal: if P[0]==1, the upper half plus M is formed as a WIDTH+1-bit sum, otherwise the upper half is used alone; that {carry, sum, P[WIDTH-1:1]} becomes the new P, i.e. a logical right shift by 1 that keeps the carry; cnt=cnt+1.
- When the iteration with cnt==WIDTH-1 completes, FSM=DONE. Exactly WIDTH iterations are performed. In DONE, P==dataA*dataB (unsigned).
- Latency: the first iteration happens on the first edge after mulreset falls. done rises WIDTH edges after that.
- busy = (FSM==RUN). done = (FSM==DONE). Both are registered state decodes.
- Commit: edge with Signal==HILO_WR in DONE: HI=P[2*WIDTH-1:WIDTH], LO=P[WIDTH-1:0], FSM=IDLE. HILO_WR in IDLE or RUN is ignored: HI/LO unchanged, no state change.
- Simultaneous MULTU-with-mulreset and HILO_WR is impossible, because there is a single Signal. Load has priority over iteration.
- HI/LO are changed only by a commit or by reset. A new MULTU does not disturb HI/LO until its own commit.
- dataOut is combinational: HI when Signal==MFHI, LO when Signal==MFLO, otherwise 0.
- No wrap-around: cnt saturates in DONE. Edges in DONE without HILO_WR or a load hold all state.
- Reset asserted mid-RUN: the operation is discarded and the block returns to IDLE with HI/LO=0.

Test Plan:
- Reset then idle: reset=0 for 2 cycles, release -> busy=0, done=0. With Signal=MFHI, and again with MFLO, dataOut=0.
- Basic: dataA=3, dataB=5, MULTU+mulreset=1 for 2 edges, then mulreset=0. After 32 edges done=1. HILO_WR, then MFLO gives dataOut=15 and MFHI gives 0. FSM is IDLE after the commit.
- Max operands: 0xFFFFFFFF x 0xFFFFFFFF -> after commit, HI=0xFFFFFFFE and LO=0x00000001. Checks carry retention.
- Upper carry: 0x80000000 x 2 -> HI=0x00000001, LO=0x00000000. Early HILO_WR issued at iteration 10 is ignored: HI/LO keep prior values and busy stays 1.
- Restart: MULTU 7x9 runs to iteration 15, then reload with 6x6 -> done after 32 further iterations. Commit gives LO=36, not 63.
- Async reset mid-RUN: reset=0 between clock edges at iteration 20 -> busy=0 and HI=LO=0 immediately. A subsequent 2x2 run commits LO=4.
